// File: rtl/ps2_pkg.sv
// Shared types and constants for the device-side PS/2 engine.
//  - ps2_state_e : engine FSM states
//  - FRAME_TX_BITS / FRAME_RX_BITS : cells per device->host / host->device frame
//  - odd_parity() : parity bit that makes data + parity carry an odd number of ones
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StGap,
      StInhibit,
      StRx,
      StAck
   } ps2_state_e;

   localparam int unsigned FRAME_TX_BITS = 11;
   localparam int unsigned FRAME_RX_BITS = 10;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_device_emu_if.sv
// User-side handshake bundle of the PS/2 device emulator.
//  master : user logic (offers scan codes, consumes host commands)
//  slave  : ps2_device_emu
//  tx_data/tx_valid/tx_ready : scan-code byte handshake
//  rx_data/rx_valid/rx_parity_err : received host command, rx_valid is a 1-cycle pulse
//  rx_frame_err : 1-cycle pulse, host frame dropped (bad stop bit)
//  busy : engine not idle
interface ps2_device_emu_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       busy;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, busy
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, busy
   );

endinterface

// File: rtl/ps2_phase_timer.sv
// Loadable down-counter pacing PS/2 clock half-phases and the post-frame idle gap.
//  clk, rst : system clock, synchronous active-low reset
//  load     : restart the count this cycle
//  sel_gap  : on load, use INTER_GAP instead of HALF_PERIOD
//  zero     : count reached 0 (last cycle of the current phase)
//  mid      : count == HALF_PERIOD/2 (data sample point inside a half-phase)
module ps2_phase_timer
   import ps2_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 1000,
   parameter int unsigned INTER_GAP   = 2000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic sel_gap,
   output logic zero,
   output logic mid
);

   localparam int unsigned MaxLoad = (HALF_PERIOD > INTER_GAP) ? HALF_PERIOD : INTER_GAP;
   localparam int unsigned CntW    = $clog2(MaxLoad + 1);
   localparam logic [CntW-1:0] HalfLoad = CntW'(HALF_PERIOD - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'(INTER_GAP - 1);
   localparam logic [CntW-1:0] MidVal   = CntW'(HALF_PERIOD / 2);

   logic [CntW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= sel_gap ? GapLoad : HalfLoad;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);
   assign mid  = (count_q == MidVal);

endmodule

// File: rtl/ps2_device_emu.sv
// Device-side (keyboard end) PS/2 engine. Generates the PS/2 clock, sends scan-code
// frames to the host and receives host command frames with acknowledge.
//  clk, rst        : system clock, synchronous active-low reset
//  bus             : user handshake bundle (slave side)
//  ps2_clk_i       : PS/2 clock line level (asynchronous)
//  ps2_data_i      : PS/2 data line level (asynchronous)
//  ps2_clk_en_o_   : 0 pulls the clock line low, 1 releases it
//  ps2_data_en_o_  : 0 pulls the data line low, 1 releases it
module ps2_device_emu
   import ps2_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 1000,
   parameter int unsigned INTER_GAP   = 2000
) (
   input  logic                    clk,
   input  logic                    rst,
   ps2_device_emu_if.slave         bus,
   input  logic                    ps2_clk_i,
   input  logic                    ps2_data_i,
   output logic                    ps2_clk_en_o_,
   output logic                    ps2_data_en_o_
);

   ps2_state_e state_q;
   logic [1:0] clk_sync_q, data_sync_q;
   logic       clk_s, data_s;
   logic [3:0] bit_cnt_q, next_bit;
   logic       low_phase_q;
   logic       held_q;
   logic [7:0] tx_byte_q;
   logic [9:0] rx_sh_q;
   logic       clk_en_q, data_en_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q, rx_perr_q, rx_ferr_q;
   logic       tmr_load, tmr_gap, tmr_zero, tmr_mid;
   logic       tx_last, rx_last;
   logic [FRAME_TX_BITS-1:0] frame;

   // Lines idle high, so the synchronizers reset to 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
      end
   end

   assign clk_s    = clk_sync_q[1];
   assign data_s   = data_sync_q[1];
   assign frame    = {1'b1, odd_parity(tx_byte_q), tx_byte_q, 1'b0};
   assign next_bit = bit_cnt_q + 4'd1;
   assign tx_last  = (bit_cnt_q == 4'(FRAME_TX_BITS - 1));
   assign rx_last  = (bit_cnt_q == 4'(FRAME_RX_BITS - 1));

   // Timer restarts on every phase boundary; loads on exits that need none are harmless.
   always_comb begin
      tmr_load = 1'b0;
      tmr_gap  = 1'b0;
      unique case (state_q)
         StIdle:    tmr_load = clk_s && (held_q || bus.tx_valid);
         StTx: begin
            tmr_load = tmr_zero;
            tmr_gap  = low_phase_q && tx_last;
         end
         StInhibit: tmr_load = clk_s && !data_s;
         StRx, StAck: tmr_load = tmr_zero;
         default: ;
      endcase
   end

   ps2_phase_timer #(
      .HALF_PERIOD (HALF_PERIOD),
      .INTER_GAP   (INTER_GAP)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .sel_gap (tmr_gap),
      .zero    (tmr_zero),
      .mid     (tmr_mid)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         low_phase_q <= 1'b0;
         held_q      <= 1'b0;
         tx_byte_q   <= '0;
         rx_sh_q     <= '0;
         clk_en_q    <= 1'b1;
         data_en_q   <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_perr_q   <= 1'b0;
         rx_ferr_q   <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!clk_s) begin
                  state_q <= StInhibit;
               end else if (held_q || bus.tx_valid) begin
                  if (!held_q) begin
                     tx_byte_q <= bus.tx_data;
                     held_q    <= 1'b1;
                  end
                  state_q     <= StTx;
                  bit_cnt_q   <= '0;
                  low_phase_q <= 1'b0;
                  clk_en_q    <= 1'b1;
                  data_en_q   <= 1'b0;  // start bit
               end
            end
            StTx: begin
               if (tmr_zero) begin
                  if (!low_phase_q) begin
                     // Host may only abort before the stop bit goes out.
                     if (!clk_s && !tx_last) begin
                        state_q   <= StInhibit;
                        clk_en_q  <= 1'b1;
                        data_en_q <= 1'b1;
                     end else begin
                        low_phase_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                     end
                  end else begin
                     clk_en_q <= 1'b1;
                     if (tx_last) begin
                        data_en_q <= 1'b1;
                        held_q    <= 1'b0;
                        state_q   <= StGap;
                     end else begin
                        bit_cnt_q   <= next_bit;
                        low_phase_q <= 1'b0;
                        data_en_q   <= frame[next_bit];
                     end
                  end
               end
            end
            StGap: begin
               if (tmr_zero) state_q <= StIdle;
            end
            StInhibit: begin
               clk_en_q  <= 1'b1;
               data_en_q <= 1'b1;
               if (clk_s) begin
                  if (!data_s) begin
                     // Request-to-send: host holds data low as the start bit.
                     state_q     <= StRx;
                     bit_cnt_q   <= '0;
                     low_phase_q <= 1'b1;
                     clk_en_q    <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StRx: begin
               if (tmr_mid && !low_phase_q) rx_sh_q <= {data_s, rx_sh_q[9:1]};
               if (tmr_zero) begin
                  if (low_phase_q) begin
                     low_phase_q <= 1'b0;
                     clk_en_q    <= 1'b1;
                  end else if (rx_last) begin
                     if (rx_sh_q[9]) begin
                        state_q     <= StAck;
                        low_phase_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        data_en_q   <= 1'b0;
                     end else begin
                        rx_ferr_q <= 1'b1;
                        state_q   <= StIdle;
                        clk_en_q  <= 1'b1;
                        data_en_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q   <= next_bit;
                     low_phase_q <= 1'b1;
                     clk_en_q    <= 1'b0;
                  end
               end
            end
            StAck: begin
               if (tmr_zero) begin
                  if (low_phase_q) begin
                     low_phase_q <= 1'b0;
                     clk_en_q    <= 1'b1;
                  end else begin
                     data_en_q  <= 1'b1;
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_sh_q[7:0];
                     rx_perr_q  <= (rx_sh_q[8] != odd_parity(rx_sh_q[7:0]));
                     state_q    <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // rst gates tx_ready so it reads 0 for the whole time reset is held.
   assign bus.tx_ready      = rst && (state_q == StIdle) && !held_q && clk_s;
   assign bus.busy          = (state_q != StIdle);
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_valid      = rx_valid_q;
   assign bus.rx_parity_err = rx_perr_q;
   assign bus.rx_frame_err  = rx_ferr_q;
   assign ps2_clk_en_o_     = clk_en_q;
   assign ps2_data_en_o_    = data_en_q;

endmodule
